input_conditioner: RTL and testbench

- Upstream front end for the lab board's raw switches and push-button. Output feeds the clock divider select, the BCD counter direction bits, the ALU/control-decoder selects and the reset/step button.
- Synchronises every raw input into the clk domain.
- Debounces the switch bank and one push-button.
- Produces clean levels plus single-cycle press, release and switch-change pulses for downstream counters and control logic.

---
 rtl/input_cond_pkg.sv | 16 +
 rtl/input_conditioner_sync2.sv | 27 ++
 rtl/input_conditioner.sv | 197 +++++++++++++++++++
 tb/tb_input_conditioner.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/input_cond_pkg.sv
// Shared constants for the input conditioner: button FSM state encodings
// and default timing for a 100 MHz system clock.
package input_cond_pkg;

  // Button debounce FSM states
  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] HELD         = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  // Defaults: 9 slide switches, 10 ms debounce, 1 s long press at 100 MHz
  localparam int unsigned DEF_SW_W            = 32'd9;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 32'd1000000;
  localparam int unsigned DEF_LONG_CYCLES     = 32'd100000000;

endpackage

// File: rtl/input_conditioner_sync2.sv
// Two-flop synchroniser, parameterised width, asynchronous active-low reset.
module sync2 #(
  parameter int unsigned W = 32'd1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  // Two-stage capture of the asynchronous input into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/input_conditioner.sv
// Input conditioner: synchronises and debounces the switch bank and the
// push-button, producing clean levels plus single-cycle event pulses.
// Optional long-press detection is built when INPUT_COND_LONG_PRESS_EN is
// defined; otherwise btn_long is tied low.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int unsigned SW_W            = DEF_SW_W,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SW_W-1:0] sw_raw,
  input  logic            btn_raw,
  output logic [SW_W-1:0] sw_clean,
  output logic            sw_changed,
  output logic            btn_level,
  output logic            btn_press,
  output logic            btn_release,
  output logic            btn_long
);

  localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

  // Reject parameter sets where the long-press window cannot exceed debounce
  if ((DEBOUNCE_CYCLES < 32'd2) || (LONG_CYCLES <= DEBOUNCE_CYCLES)) begin : g_param_check
    $error("input_conditioner: illegal DEBOUNCE_CYCLES/LONG_CYCLES combination");
  end

  logic [SW_W-1:0]  w_s_s;
  logic [0:0]       w_b_vec;
  logic             w_b_s;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_btn_level;
  logic             r_btn_press;
  logic             r_btn_release;

  logic [CNT_W-1:0] r_tick_cnt;
  logic             w_tick;
  logic [SW_W-1:0]  r_sw_prev;
  logic [SW_W-1:0]  r_sw_clean;
  logic             r_sw_changed;

  sync2 #(.W(SW_W)) u_sync_sw (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (sw_raw),
    .o_q   (w_s_s)
  );

  sync2 #(.W(32'd1)) u_sync_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (btn_raw),
    .o_q   (w_b_vec)
  );

  assign w_b_s = w_b_vec[0];

  // Button debounce FSM: a level must be stable for DEBOUNCE_CYCLES to count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_btn_level   <= 1'b0;
      r_btn_press   <= 1'b0;
      r_btn_release <= 1'b0;
    end else begin
      r_btn_press   <= 1'b0;
      r_btn_release <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_b_s) begin
            r_state <= PRESS_WAIT;
            r_cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!w_b_s) begin
            r_state <= IDLE;
          end else if (r_cnt == CNT_LAST) begin
            r_state     <= HELD;
            r_btn_level <= 1'b1;
            r_btn_press <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        HELD: begin
          if (!w_b_s) begin
            r_state <= RELEASE_WAIT;
            r_cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (w_b_s) begin
            r_state <= HELD;
          end else if (r_cnt == CNT_LAST) begin
            r_state       <= IDLE;
            r_btn_level   <= 1'b0;
            r_btn_release <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_cnt       <= '0;
          r_btn_level <= 1'b0;
        end
      endcase
    end
  end

  assign w_tick = (r_tick_cnt == CNT_LAST);

  // Free-running sample tick for the switch bank, independent of the button
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + CNT_ONE;
    end
  end

  // Switch bank accepts a value only when equal on two consecutive ticks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_prev    <= '0;
      r_sw_clean   <= '0;
      r_sw_changed <= 1'b0;
    end else begin
      r_sw_changed <= 1'b0;
      if (w_tick) begin
        r_sw_prev <= w_s_s;
        if ((w_s_s == r_sw_prev) && (w_s_s != r_sw_clean)) begin
          r_sw_clean   <= w_s_s;
          r_sw_changed <= 1'b1;
        end
      end
    end
  end

`ifdef INPUT_COND_LONG_PRESS_EN
  localparam int unsigned      HOLD_W    = $clog2(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 32'd1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(32'd1);

  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_long_fired;
  logic              r_btn_long;
  logic              w_holding;

  // Release bounces stay inside the press, so the hold count keeps running
  assign w_holding = (r_state == HELD) || (r_state == RELEASE_WAIT);

  // Hold counter saturates; one long pulse per press while still HELD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt   <= '0;
      r_long_fired <= 1'b0;
      r_btn_long   <= 1'b0;
    end else if (r_state == IDLE) begin
      r_hold_cnt   <= '0;
      r_long_fired <= 1'b0;
      r_btn_long   <= 1'b0;
    end else begin
      r_btn_long <= 1'b0;
      if (w_holding && (r_hold_cnt != HOLD_LAST)) begin
        r_hold_cnt <= r_hold_cnt + HOLD_ONE;
      end
      if ((r_state == HELD) && (r_hold_cnt == HOLD_LAST) && !r_long_fired) begin
        r_btn_long   <= 1'b1;
        r_long_fired <= 1'b1;
      end
    end
  end

  assign btn_long = r_btn_long;
`else
  assign btn_long = 1'b0;
`endif

  assign sw_clean    = r_sw_clean;
  assign sw_changed  = r_sw_changed;
  assign btn_level   = r_btn_level;
  assign btn_press   = r_btn_press;
  assign btn_release = r_btn_release;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
module tb_input_conditioner;

  localparam int unsigned SW_W = 9;
  localparam int unsigned DEB  = 4;
  localparam int unsigned LNG  = 20;

  logic            clk;
  logic            rst_n;
  logic [SW_W-1:0] sw_raw;
  logic            btn_raw;
  logic [SW_W-1:0] sw_clean;
  logic            sw_changed;
  logic            btn_level;
  logic            btn_press;
  logic            btn_release;
  logic            btn_long;

  int n_checks;
  int n_fail;

  input_conditioner #(
    .SW_W            (SW_W),
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LNG)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw_raw      (sw_raw),
    .btn_raw     (btn_raw),
    .sw_clean    (sw_clean),
    .sw_changed  (sw_changed),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_long    (btn_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic btn;
    logic press;
    logic rel;
    logic level;
  } vec_t;

  vec_t tbl [20];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  initial begin
    int press_cnt;
    int rel_cnt;
    int both_cnt;
    int chg_cnt;
    int long_cnt;
    int long_edge;
    int bad;
    int done_at;
    int exp_long_cnt;
    logic [SW_W-1:0] sw_a;
    logic [SW_W-1:0] sw_g;

    n_checks = 0;
    n_fail   = 0;
    sw_a     = 9'h1A5;
    sw_g     = 9'h1A4;
`ifdef INPUT_COND_LONG_PRESS_EN
    exp_long_cnt = 1;
`else
    exp_long_cnt = 0;
`endif

    // Clean press then clean release; entry i is observed after edge i+1
    for (int i = 0; i < 20; i++) begin
      tbl[i].btn   = (i < 10);
      tbl[i].press = (i == 6);
      tbl[i].rel   = (i == 16);
      tbl[i].level = (i >= 6) && (i <= 15);
    end

    rst_n   = 1'b0;
    sw_raw  = '0;
    btn_raw = 1'b0;
    repeat (3) step();
    check("reset_state",
          {17'd0, sw_clean, sw_changed, btn_level, btn_press, btn_release, btn_long}, 32'd0);
    rst_n = 1'b1;
    repeat (3) step();

    for (int i = 0; i < 20; i++) begin
      btn_raw = tbl[i].btn;
      step();
      check($sformatf("vec%0d", i),
            {27'd0, btn_press, btn_release, btn_level, btn_long, sw_changed},
            {27'd0, tbl[i].press, tbl[i].rel, tbl[i].level, 1'b0, 1'b0});
    end
    repeat (4) step();

    // Bounce: 1,0,1,0 then quiet low; never a press, level stays low
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      btn_raw = (i < 4) ? ((i % 2) == 0) : 1'b0;
      step();
      if (btn_press || btn_level) bad++;
    end
    check("bounce_no_press", bad, 0);

    // Hold, release with one bounce, then settle: one press, one release
    press_cnt = 0; rel_cnt = 0; both_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (i < 12)       btn_raw = 1'b1;
      else if (i == 13) btn_raw = 1'b1;
      else              btn_raw = 1'b0;
      step();
      if (btn_press)   press_cnt++;
      if (btn_release) rel_cnt++;
      if (btn_press && btn_release) both_cnt++;
    end
    check("hold_press_count", press_cnt, 1);
    check("hold_release_count", rel_cnt, 1);
    check("press_release_overlap", both_cnt, 0);
    check("hold_level_end", {31'd0, btn_level}, 32'd0);

    // Switch bank change: must land within 2 ticks + 3 cycles
    sw_raw  = sw_a;
    chg_cnt = 0;
    done_at = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (sw_changed) chg_cnt++;
      if ((done_at < 0) && (sw_clean == sw_a)) done_at = i;
    end
    check("sw_clean_value", {23'd0, sw_clean}, {23'd0, sw_a});
    check("sw_change_in_time", (done_at > 0) && (done_at <= 2 * DEB + 3), 1);
    check("sw_changed_pulses", chg_cnt, 1);

    // One-cycle glitch on bit 0 at each tick phase is filtered
    for (int ph = 0; ph < 4; ph++) begin
      repeat (ph) step();
      chg_cnt = 0;
      sw_raw  = sw_g;
      step();
      if (sw_changed) chg_cnt++;
      sw_raw = sw_a;
      for (int i = 0; i < 12; i++) begin
        step();
        if (sw_changed) chg_cnt++;
      end
      check($sformatf("glitch_ph%0d", ph), {chg_cnt[22:0], sw_clean}, {23'd0, sw_a});
    end

    // Reset asserted in PRESS_WAIT clears everything at once
    btn_raw = 1'b1;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    check("async_reset_clear",
          {17'd0, sw_clean, sw_changed, btn_level, btn_press, btn_release, btn_long}, 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    bad = 0;
    for (int e = 1; e <= 10; e++) begin
      step();
      if (btn_press != (e == 7)) bad++;
      if (btn_level != (e >= 7)) bad++;
    end
    check("press_after_reset", bad, 0);

    // Long press: hold 30 cycles from idle, HELD entered at edge 7
    btn_raw = 1'b0;
    repeat (15) step();
    btn_raw   = 1'b1;
    long_cnt  = 0;
    long_edge = -1;
    for (int e = 1; e <= 37; e++) begin
      if (e > 30) btn_raw = 1'b0;
      step();
      if (btn_long) begin
        long_cnt++;
        long_edge = e;
      end
    end
    check("long_count", long_cnt, exp_long_cnt);
`ifdef INPUT_COND_LONG_PRESS_EN
    check("long_edge", long_edge, 27);
`endif
    repeat (8) step();
    check("final_idle", {30'd0, btn_level, btn_long}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
